// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction-memory loader.
package imem_pkg;

  localparam int WORD_SIZE_POW = 2;
  localparam int WORD_SIZE     = 4;
  localparam int ADDR_WIDTH    = 64;
  localparam int DATA_WIDTH    = 32;

  typedef logic [WORD_SIZE-1:0][7:0] imem_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } imem_loader_state_e;

  // Places one byte into the given lane of a partially assembled word.
  function automatic imem_word_t put_lane(input imem_word_t word, input logic [1:0] lane,
                                          input logic [7:0] data);
    imem_word_t result;
    result       = word;
    result[lane] = data;
    return result;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Optional running word checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_DEPTH_POW = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     byte_valid_i,
  input  logic [7:0]               byte_data_i,
  input  logic                     byte_last_i,
  output logic                     byte_ready_o,
  output logic                     wr_en_o,
  output logic [ADDR_WIDTH-1:0]    wr_addr_o,
  output logic [DATA_WIDTH-1:0]    wr_data_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [MEM_DEPTH_POW:0]   word_count_o,
  output logic [DATA_WIDTH-1:0]    checksum_o
);

  localparam int CW = MEM_DEPTH_POW + 1;
  localparam logic [CW-1:0] CAPACITY = {1'b1, {MEM_DEPTH_POW{1'b0}}};

  imem_loader_state_e    state_r;
  logic [1:0]            byte_idx_r;
  logic [CW-1:0]         word_idx_r;
  imem_word_t            asm_r;
  logic                  wr_en_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [DATA_WIDTH-1:0] wr_data_r;

  logic       accept_s;
  logic       full_s;
  logic       complete_s;
  imem_word_t word_s;

  assign accept_s   = (state_r == LOAD) && byte_valid_i;
  assign full_s     = (word_idx_r == CAPACITY);
  assign complete_s = byte_last_i || (byte_idx_r == 2'd3);
  // Lanes above the current one are still zero because asm_r clears after every word.
  assign word_s     = put_lane(asm_r, byte_idx_r, byte_data_i);

  // Load FSM, byte packing and the registered memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      byte_idx_r <= 2'd0;
      word_idx_r <= '0;
      asm_r      <= '0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
    end else begin
      wr_en_r <= 1'b0;
      case (state_r)
        LOAD: begin
          if (accept_s) begin
            if (full_s) begin
              state_r <= ERR;
            end else begin
              byte_idx_r <= byte_idx_r + 2'd1;
              if (complete_s) begin
                wr_en_r    <= 1'b1;
                wr_addr_r  <= {{(ADDR_WIDTH-CW-WORD_SIZE_POW){1'b0}}, word_idx_r, 2'b00};
                wr_data_r  <= word_s;
                word_idx_r <= word_idx_r + CW'(1);
                asm_r      <= '0;
                if (byte_last_i) begin
                  state_r <= DONE;
                end else begin
                  state_r <= LOAD;
                end
              end else begin
                asm_r <= word_s;
              end
            end
          end else begin
            state_r <= LOAD;
          end
        end
        IDLE, DONE, ERR: begin
          if (start_i) begin
            state_r    <= LOAD;
            byte_idx_r <= 2'd0;
            word_idx_r <= '0;
            asm_r      <= '0;
          end else begin
            state_r <= state_r;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_r;

  // Wrap-around sum of every word written during the current load.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_r <= 32'd0;
    end else if ((state_r != LOAD) && start_i) begin
      checksum_r <= 32'd0;
    end else if (accept_s && !full_s && complete_s) begin
      checksum_r <= checksum_r + word_s;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum_o = checksum_r;
`else
  assign checksum_o = 32'd0;
`endif

  assign byte_ready_o = (state_r == LOAD);
  assign busy_o       = (state_r == LOAD);
  assign done_o       = (state_r == DONE);
  assign err_o        = (state_r == ERR);
  assign wr_en_o      = wr_en_r;
  assign wr_addr_o    = wr_addr_r;
  assign wr_data_o    = wr_data_r;
  assign word_count_o = word_idx_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a default-depth instance and a 4-word instance for overflow.
module tb_imem_loader;
  import imem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, valid_a, last_a;
  logic [7:0]  data_a;
  logic        ready_a, wr_en_a, busy_a, done_a, err_a;
  logic [63:0] wr_addr_a;
  logic [31:0] wr_data_a, csum_a;
  logic [10:0] cnt_a;

  logic        rst_b, start_b, valid_b, last_b;
  logic [7:0]  data_b;
  logic        ready_b, wr_en_b, busy_b, done_b, err_b;
  logic [63:0] wr_addr_b;
  logic [31:0] wr_data_b, csum_b;
  logic [2:0]  cnt_b;

  imem_loader #(.MEM_DEPTH_POW(10)) dut_a (
    .clk(clk), .rst(rst_a), .start_i(start_a), .byte_valid_i(valid_a),
    .byte_data_i(data_a), .byte_last_i(last_a), .byte_ready_o(ready_a),
    .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a), .wr_data_o(wr_data_a),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
    .word_count_o(cnt_a), .checksum_o(csum_a)
  );

  imem_loader #(.MEM_DEPTH_POW(2)) dut_b (
    .clk(clk), .rst(rst_b), .start_i(start_b), .byte_valid_i(valid_b),
    .byte_data_i(data_b), .byte_last_i(last_b), .byte_ready_o(ready_b),
    .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b), .wr_data_o(wr_data_b),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
    .word_count_o(cnt_b), .checksum_o(csum_b)
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    int          cnt;
    logic [31:0] csum;
    logic [63:0] t;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          cnt_model[2];
  logic [31:0] csum_model[2];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called right after the accepting edge; the write must appear at the following negedge.
  task automatic push(input int sel, input logic [63:0] addr, input logic [31:0] data);
    exp_t e;
    cnt_model[sel]++;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_model[sel] = csum_model[sel] + data;
`endif
    e.addr = addr;
    e.data = data;
    e.cnt  = cnt_model[sel];
    e.csum = csum_model[sel];
    e.t    = $time + 64'd5;
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (wr_en_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 wr_addr_a, wr_data_a);
      end else begin
        e = q_a.pop_front();
        check("a_wr_time", $time, e.t);
        check("a_wr_addr", wr_addr_a, e.addr);
        check("a_wr_data", 64'(wr_data_a), 64'(e.data));
        check("a_word_count", 64'(cnt_a), 64'(e.cnt));
        check("a_checksum", 64'(csum_a), 64'(e.csum));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (wr_en_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 wr_addr_b, wr_data_b);
      end else begin
        e = q_b.pop_front();
        check("b_wr_time", $time, e.t);
        check("b_wr_addr", wr_addr_b, e.addr);
        check("b_wr_data", 64'(wr_data_b), 64'(e.data));
        check("b_word_count", 64'(cnt_b), 64'(e.cnt));
        check("b_checksum", 64'(csum_b), 64'(e.csum));
      end
    end
  end

  task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l,
                       input logic st);
    if (sel == 0) begin
      valid_a = v; data_a = d; last_a = l; start_a = st;
    end else begin
      valid_b = v; data_b = d; last_b = l; start_b = st;
    end
  endtask

  task automatic idle(input int sel, input logic st);
    @(negedge clk);
    drive(sel, 1'b0, 8'h00, 1'b0, st);
  endtask

  task automatic do_start(input int sel);
    idle(sel, 1'b1);
    @(posedge clk);
    idle(sel, 1'b0);
    cnt_model[sel]  = 0;
    csum_model[sel] = 32'd0;
  endtask

  // Presents one byte and returns at the edge that accepts it (acc=0 if never ready).
  task automatic send(input int sel, input logic [7:0] d, input logic l, input logic st,
                      output logic acc);
    acc = 1'b0;
    @(negedge clk);
    drive(sel, 1'b1, d, l, st);
    for (int t = 0; t < 20; t++) begin
      if ((sel == 0) ? ready_a : ready_b) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_ready"}, 64'(ready_a), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en_a), 64'd0);
    check({tag, "_wr_addr"}, wr_addr_a, 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data_a), 64'd0);
    check({tag, "_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_done"}, 64'(done_a), 64'd0);
    check({tag, "_err"}, 64'(err_a), 64'd0);
    check({tag, "_count"}, 64'(cnt_a), 64'd0);
    check({tag, "_checksum"}, 64'(csum_a), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic        acc;
    logic [31:0] exp_b[4];
    exp_b = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    rst_a = 1'b1; rst_b = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_a("reset");
    rst_a = 1'b0; rst_b = 1'b0;

    // Single word 0x00000013.
    do_start(0);
    check("start_ready", 64'(ready_a), 64'd1);
    check("start_busy", 64'(busy_a), 64'd1);
    send(0, 8'h13, 1'b0, 1'b0, acc);
    send(0, 8'h00, 1'b0, 1'b0, acc);
    send(0, 8'h00, 1'b0, 1'b0, acc);
    send(0, 8'h00, 1'b1, 1'b0, acc);
    check("t1_accept", 64'(acc), 64'd1);
    push(0, 64'h0, 32'h00000013);
    idle(0, 1'b0);
    check("t1_done", 64'(done_a), 64'd1);
    check("t1_ready_low", 64'(ready_a), 64'd0);
    check("t1_busy_low", 64'(busy_a), 64'd0);
    check("t1_count", 64'(cnt_a), 64'd1);

    // Nine bytes at full rate, last word zero padded.
    do_start(0);
    for (int i = 1; i <= 9; i++) begin
      send(0, 8'(i), (i == 9), 1'b0, acc);
      check("t2_accept", 64'(acc), 64'd1);
      if (i == 4) push(0, 64'h0, 32'h04030201);
      if (i == 8) push(0, 64'h4, 32'h08070605);
      if (i == 9) push(0, 64'h8, 32'h00000009);
    end
    idle(0, 1'b0);
    check("t2_done", 64'(done_a), 64'd1);
    check("t2_count", 64'(cnt_a), 64'd3);

    // Reset after the sixth byte of a twelve-byte load.
    do_start(0);
    for (int i = 1; i <= 6; i++) begin
      send(0, 8'(8'h20 + i), 1'b0, 1'b0, acc);
      if (i == 4) push(0, 64'h0, 32'h24232221);
    end
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_a("midrst");
    rst_a = 1'b0;

    // Reset on the edge that would complete a word cancels that write.
    do_start(0);
    for (int i = 1; i <= 3; i++) send(0, 8'(8'h30 + i), 1'b0, 1'b0, acc);
    @(negedge clk);
    drive(0, 1'b1, 8'h34, 1'b0, 1'b1);
    rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("cancel_wr_en", 64'(wr_en_a), 64'd0);
    check("cancel_idle", 64'(busy_a), 64'd0);
    do_start(0);
    send(0, 8'hAA, 1'b0, 1'b0, acc);
    send(0, 8'hBB, 1'b0, 1'b0, acc);
    send(0, 8'hCC, 1'b0, 1'b0, acc);
    send(0, 8'hDD, 1'b1, 1'b0, acc);
    push(0, 64'h0, 32'hDDCCBBAA);
    idle(0, 1'b0);
    check("restart_count", 64'(cnt_a), 64'd1);

    // Gappy stream with start pulses inside LOAD.
    do_start(0);
    for (int i = 1; i <= 9; i++) begin
      repeat ($urandom_range(0, 3)) idle(0, (i == 3));
      send(0, 8'(i), (i == 9), (i == 5), acc);
      if (i == 4) push(0, 64'h0, 32'h04030201);
      if (i == 8) push(0, 64'h4, 32'h08070605);
      if (i == 9) push(0, 64'h8, 32'h00000009);
    end
    idle(0, 1'b0);
    check("t4_done", 64'(done_a), 64'd1);
    check("t4_count", 64'(cnt_a), 64'd3);

    // Checksum wrap-around: 0xFFFFFFFF + 0x00000002.
    do_start(0);
    for (int i = 0; i < 4; i++) send(0, 8'hFF, 1'b0, 1'b0, acc);
    push(0, 64'h0, 32'hFFFFFFFF);
    send(0, 8'h02, 1'b0, 1'b0, acc);
    send(0, 8'h00, 1'b0, 1'b0, acc);
    send(0, 8'h00, 1'b0, 1'b0, acc);
    send(0, 8'h00, 1'b1, 1'b0, acc);
    push(0, 64'h4, 32'h00000002);
    idle(0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t5_checksum", 64'(csum_a), 64'h1);
`else
    check("t5_checksum", 64'(csum_a), 64'h0);
`endif

    // Overflow on a four-word memory.
    do_start(1);
    for (int i = 1; i <= 16; i++) begin
      send(1, 8'(i), 1'b0, 1'b0, acc);
      if (i % 4 == 0) push(1, 64'((i / 4 - 1) * 4), exp_b[i / 4 - 1]);
    end
    send(1, 8'h11, 1'b0, 1'b0, acc);
    check("t6_byte17_accept", 64'(acc), 64'd1);
    idle(1, 1'b0);
    check("t6_err", 64'(err_b), 64'd1);
    check("t6_ready_low", 64'(ready_b), 64'd0);
    check("t6_count", 64'(cnt_b), 64'd4);
    send(1, 8'h12, 1'b0, 1'b0, acc);
    check("t6_byte18_dropped", 64'(acc), 64'd0);
    idle(1, 1'b0);
    check("t6_err_hold", 64'(err_b), 64'd1);

    repeat (3) @(negedge clk);
    check("q_a_empty", 64'(q_a.size()), 64'd0);
    check("q_b_empty", 64'(q_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the instruction memory. It accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit instruction words. It drives a single-cycle write port into instruction memory at consecutive word-aligned 64-bit byte addresses starting at 0. It is used at boot or under test control to fill instruction memory before the core is released from reset.

## Interface
Parameters:
- MEM_DEPTH_POW, 10, log2 of instruction-memory depth in 32-bit words; capacity is 1 << MEM_DEPTH_POW words.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- start_i  input  1  pulse; begins a new load from address 0.
- byte_valid_i  input  1  stream byte present.
- byte_data_i  input  8  stream byte.
- byte_last_i  input  1  qualifies the final byte of the image.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- wr_en_o  output  1  one-cycle write strobe to instruction memory.
- wr_addr_o  output  64  byte address of the word being written; bits [1:0] are always 0.
- wr_data_o  output  32  word being written; byte 0 is in [7:0].
- busy_o  output  1  high in LOAD.
- done_o  output  1  high in DONE.
- err_o  output  1  high in ERR.
- word_count_o  output  MEM_DEPTH_POW+1  number of words written in the current or last load.
- checksum_o  output  32  running word checksum; see Configuration.

## Operation
- States: IDLE, LOAD, DONE, ERR. Reset forces IDLE.
- IDLE, DONE, ERR:
  - start_i=1 moves to LOAD and clears the byte index (2 bits), word index, assembly register and checksum.
  - Without start_i, the state holds.
- LOAD:
  - byte_ready_o=1. A byte is accepted on an edge where byte_valid_i and byte_ready_o are both 1.
  - An accepted byte goes into lane byte_index, then byte_index increments mod 4.
  - A word completes when the byte in lane 3 is accepted, or when any byte is accepted with byte_last_i=1. On a byte_last_i completion, lanes above the final byte are zero-filled.
  - On completion, the registered write is issued: wr_addr_o = word_index << 2, zero-extended to 64 bits. Then word_index increments.
  - If byte_last_i was set, the next state is DONE.
  - If a byte is accepted while word_index == 1<<MEM_DEPTH_POW, the next state is ERR. That byte and any following bytes are dropped, and no write is issued.
- start_i in LOAD is ignored.
- word_count_o equals word_index.
- Assembly register clears after each completed word.

## Timing
- Reset values: byte_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0, err_o=0, word_count_o=0, checksum_o=0.
- start_i sampled at edge N puts the block in LOAD from cycle N+1. byte_ready_o=1 from cycle N+1.
- Write latency: if the completing byte is accepted at edge N, then wr_en_o=1 for exactly cycle N+1, with addr and data valid in that same cycle.
  - word_count_o and checksum_o reflect the word from cycle N+1.
  - wr_en_o is never high two cycles for one word. Back-to-back completions (every 4 accepted bytes) produce at most one write per cycle.
- Full-rate streaming is supported: byte_ready_o stays 1 throughout LOAD, including during write cycles.
- The edge that accepts the last byte moves the state to DONE. byte_ready_o=0 from the next cycle, while the final write is still issued in that cycle.
- Entering ERR: err_o=1 and byte_ready_o=0 from the next cycle.
- rst asserted mid-load returns to IDLE on that edge. A write pending for the following cycle is cancelled, so wr_en_o=0.
- rst has priority over start_i.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - checksum_o is the 32-bit wrap-around sum of all written words, including zero-padded final words.
  - It updates in the write cycle and is cleared on start.
- Not defined: checksum_o is tied to 0 and no adder is synthesized.

## Structure
- Shared package imem_pkg holds:
  - WORD_SIZE_POW=2 and WORD_SIZE=4.
  - ADDR_WIDTH=64 and DATA_WIDTH=32.
  - typedef imem_word_t as logic [WORD_SIZE-1:0][7:0].
  - enum imem_loader_state_e {IDLE, LOAD, DONE, ERR}.
- No sub-module. Byte packing, FSM and write register are flat in imem_loader.

## Test plan
- Reset, then start, then stream bytes 0x13,0x00,0x00,0x00 with last on the fourth byte. Expect one wr_en pulse with addr 0 and data 0x00000013, then done_o=1 and word_count_o=1.
- Stream 9 bytes 0x01..0x09 at full rate with last on the 9th byte. Expect writes with data 0x04030201 @0, 0x08070605 @4 and 0x00000009 @8 (zero pad), each one cycle after its completing byte.
- MEM_DEPTH_POW=2: stream 20 bytes. Expect 4 writes at 0x0,0x4,0x8,0xC; the 17th byte drives err_o=1, no fifth write, and byte_ready_o=0.
- Assert rst after the 6th byte of a 12-byte load. Expect all outputs at reset values and no write for the partial word. A new start then writes from addr 0.
- Toggle byte_valid_i randomly and pulse start_i during LOAD. Expect data identical to the gapless case and start_i ignored.
- With IMEM_LOADER_CHECKSUM_EN: write words 0xFFFFFFFF and 0x00000002. Expect checksum_o=0x00000001. Without the macro, expect checksum_o=0.
